// File: rtl/bank_wr_queue.sv
// bank_wr_queue
//   Circular FIFO of 32-bit write requests tagged with a 2-bit bank index.
//   Drains in order into a 1-to-4 demux, driving its select (s) and data (d)
//   with a registered one-hot write enable (we) so only the target bank
//   latches. The head is issued only when its bank reports ready; a blocked
//   head stalls every later entry.
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      producer has a request
//   in_ready      queue accepts this cycle (!full && !rst)
//   in_bank       target bank 0..3
//   in_data       write data
//   bank_ready    bit k: bank k can take a write this cycle
//   s, d          registered demux select / data
//   we            registered one-hot write enable, zero when idle
//   count         entries held, 0..DEPTH
//   empty, full   count==0 / count==DEPTH
module bank_wr_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_bank,
    input  logic [31:0]   in_data,
    input  logic [3:0]    bank_ready,
    output logic [1:0]    s,
    output logic [31:0]   d,
    output logic [3:0]    we,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [1:0]    bank_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    head_bank;
    logic          push;
    logic          issue;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign head_bank = bank_mem[rd_ptr];
    // No fall-through: an entry pushed into an empty queue is only visible
    // to issue from the following cycle.
    assign issue     = !empty && bank_ready[head_bank];

    // Storage carries no reset; stale contents are unreachable once count=0.
    always_ff @(posedge clk) begin
        if (push) begin
            bank_mem[wr_ptr] <= in_bank;
            data_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            s      <= '0;
            d      <= '0;
            we     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
                s      <= head_bank;
                d      <= data_mem[rd_ptr];
                we     <= 4'b0001 << head_bank;
            end else begin
                we     <= '0;
            end
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_wr_queue.sv
// tb_bank_wr_queue
//   Directed-vector bench for bank_wr_queue. Inputs change 1 ns after each
//   rising edge; outputs are sampled at that same point.
module tb_bank_wr_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_bank;
    logic [31:0] in_data;
    logic [3:0]  bank_ready;
    logic [1:0]  s;
    logic [31:0] d;
    logic [3:0]  we;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int checks = 0;
    int errors = 0;

    bank_wr_queue #(.DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bank    (in_bank),
        .in_data    (in_data),
        .bank_ready (bank_ready),
        .s          (s),
        .d          (d),
        .we         (we),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [1:0] b, input logic [31:0] v);
        in_valid = 1'b1;
        in_bank  = b;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_bank    = '0;
        in_data    = '0;
        bank_ready = '0;
        step();
        step();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_we", {28'b0, we}, 32'd0);
        check("rst_s", {30'b0, s}, 32'd0);
        check("rst_d", d, 32'd0);

        // 1. idle after reset release
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("idle_in_ready", {31'b0, in_ready}, 32'd1);
            check("idle_empty", {31'b0, empty}, 32'd1);
            check("idle_count", {29'b0, count}, 32'd0);
            check("idle_we", {28'b0, we}, 32'd0);
            step();
        end

        // 2. single write, two edges from accept to we
        bank_ready = 4'hF;
        push_one(2'd2, 32'hDEADBEEF);
        check("single_cnt1", {29'b0, count}, 32'd1);
        check("single_we_early", {28'b0, we}, 32'd0);
        step();
        check("single_s", {30'b0, s}, 32'd2);
        check("single_d", d, 32'hDEADBEEF);
        check("single_we", {28'b0, we}, 32'h4);
        step();
        check("single_we_off", {28'b0, we}, 32'd0);
        check("single_empty", {31'b0, empty}, 32'd1);
        check("hold_s", {30'b0, s}, 32'd2);
        check("hold_d", d, 32'hDEADBEEF);

        // 3. fill and back-pressure
        bank_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            push_one(2'(i), 32'h100 + 32'(i));
        end
        check("fill_full", {31'b0, full}, 32'd1);
        check("fill_in_ready", {31'b0, in_ready}, 32'd0);
        check("fill_count", {29'b0, count}, 32'd4);
        check("fill_we", {28'b0, we}, 32'd0);
        // push attempt while full must be ignored
        in_valid = 1'b1;
        in_bank  = 2'd1;
        in_data  = 32'hBAD0BAD0;
        step();
        in_valid = 1'b0;
        check("full_hold_cnt", {29'b0, count}, 32'd4);
        bank_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_we", {28'b0, we}, 32'(4'b0001 << i));
            check("drain_d", d, 32'h100 + 32'(i));
        end
        check("drain_empty", {31'b0, empty}, 32'd1);
        step();
        check("drain_we_off", {28'b0, we}, 32'd0);

        // 4. head-of-line blocking
        bank_ready = 4'b1000;
        push_one(2'd1, 32'hAAAA0001);
        check("hol_we0", {28'b0, we}, 32'd0);
        push_one(2'd3, 32'hBBBB0003);
        check("hol_we1", {28'b0, we}, 32'd0);
        step();
        check("hol_we2", {28'b0, we}, 32'd0);
        check("hol_count", {29'b0, count}, 32'd2);
        bank_ready = 4'b1010;
        step();
        check("hol_weA", {28'b0, we}, 32'h2);
        check("hol_dA", d, 32'hAAAA0001);
        step();
        check("hol_weB", {28'b0, we}, 32'h8);
        check("hol_dB", d, 32'hBBBB0003);
        step();
        check("hol_we_off", {28'b0, we}, 32'd0);
        check("hol_empty", {31'b0, empty}, 32'd1);

        // 5. streaming with wrap
        bank_ready = 4'hF;
        in_valid   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_bank = 2'(k);
            in_data = 32'h5000 + 32'(k);
            step();
            check("stream_count", {29'b0, count}, 32'd1);
            if (k == 0) begin
                check("stream_we0", {28'b0, we}, 32'd0);
            end else begin
                check("stream_we", {28'b0, we}, 32'(4'b0001 << ((k - 1) % 4)));
                check("stream_d", d, 32'h5000 + 32'(k - 1));
            end
        end
        in_valid = 1'b0;
        step();
        check("stream_we_last", {28'b0, we}, 32'(4'b0001 << 1));
        check("stream_d_last", d, 32'h5009);
        check("stream_count_end", {29'b0, count}, 32'd0);

        // 6. reset mid-operation
        bank_ready = 4'h0;
        for (int i = 0; i < 3; i++) begin
            push_one(2'(i), 32'h7000 + 32'(i));
        end
        check("pre_rst_count", {29'b0, count}, 32'd3);
        rst        = 1'b1;
        bank_ready = 4'hF;
        #1;
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        check("post_rst_count", {29'b0, count}, 32'd0);
        check("post_rst_we", {28'b0, we}, 32'd0);
        check("post_rst_empty", {31'b0, empty}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_stale_we", {28'b0, we}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
